// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage with a blocking data-memory interface.
// Holds the instruction leaving EX while its load/store is outstanding,
// and freezes permanently once a halt instruction reaches MEM.

package cpu_types_pkg;
  localparam int WORD_W = 32;
  localparam int REG_W  = 5;
  localparam int WSRC_W = 2;
  typedef logic [WORD_W-1:0] word_t;
endpackage

module ex_mem_stage
  import cpu_types_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic [WORD_W-1:0] pc_EX,
  input  logic [WORD_W-1:0] instr_EX,
  input  logic [WORD_W-1:0] alu_out_EX,
  input  logic [WORD_W-1:0] store_EX,
  input  logic [REG_W-1:0]  wsel_EX,
  input  logic              MemWr_EX,
  input  logic              MemRead_EX,
  input  logic              MemtoReg_EX,
  input  logic              RegWr_EX,
  input  logic              is_halt_EX,
  input  logic              datomic_EX,
  input  logic [WSRC_W-1:0] WriteSrc_EX,
  input  logic              stall_EX_MEM,
  input  logic              flush_EX_MEM,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dload,
  output logic              dREN,
  output logic              dWEN,
  output logic              datomic,
  output logic [WORD_W-1:0] daddr,
  output logic [WORD_W-1:0] dstore,
  output logic [WORD_W-1:0] pc_MEM,
  output logic [WORD_W-1:0] instr_MEM,
  output logic [WORD_W-1:0] alu_out_MEM,
  output logic [WORD_W-1:0] dload_MEM,
  output logic [REG_W-1:0]  wsel_MEM,
  output logic              RegWr_MEM,
  output logic              MemtoReg_MEM,
  output logic              halt_MEM,
  output logic              mem_busy,
  output logic [WSRC_W-1:0] WriteSrc_MEM
);

  typedef enum logic [1:0] {IDLE, ACCESS, HALTED} state_t;

  state_t state, state_next;

  word_t store_q;
  logic  memrd_q;
  logic  memwr_q;
  logic  atomic_q;
  logic  advance;
  logic  access_done;
  logic  is_load;

  // A store wins when both request bits are set, so only a pure read is a load.
  assign is_load     = memrd_q && !memwr_q;
  assign access_done = (state == ACCESS) && dhit;
  assign mem_busy    = (state == ACCESS) && !dhit;
  // Flush may punch through a stall, but never through a pending access or a halt.
  assign advance     = !mem_busy && !halt_MEM && (!stall_EX_MEM || flush_EX_MEM);

  assign dREN    = (state == ACCESS) && is_load;
  assign dWEN    = (state == ACCESS) && memwr_q;
  assign datomic = (state == ACCESS) && atomic_q;
  assign daddr   = alu_out_MEM;
  assign dstore  = store_q;

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  // Next state: follow the incoming entry on advance; a completed access that
  // cannot advance (stalled) drops back to IDLE so it is not reissued.
  always_comb begin
    state_next = state;
    if (advance) begin
      if (!flush_EX_MEM && (MemRead_EX || MemWr_EX)) state_next = ACCESS;
      else if (!flush_EX_MEM && is_halt_EX)          state_next = HALTED;
      else                                           state_next = IDLE;
    end else if (access_done) begin
      state_next = IDLE;
    end
  end

  // Stage register: capture, bubble or hold; load data tracks the entry leaving.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_MEM       <= '0;
      instr_MEM    <= '0;
      alu_out_MEM  <= '0;
      store_q      <= '0;
      wsel_MEM     <= '0;
      memrd_q      <= 1'b0;
      memwr_q      <= 1'b0;
      atomic_q     <= 1'b0;
      MemtoReg_MEM <= 1'b0;
      RegWr_MEM    <= 1'b0;
      halt_MEM     <= 1'b0;
      WriteSrc_MEM <= '0;
      dload_MEM    <= '0;
    end else begin
      if (advance) begin
        if (flush_EX_MEM) begin
          pc_MEM       <= '0;
          instr_MEM    <= '0;
          alu_out_MEM  <= '0;
          store_q      <= '0;
          wsel_MEM     <= '0;
          memrd_q      <= 1'b0;
          memwr_q      <= 1'b0;
          atomic_q     <= 1'b0;
          MemtoReg_MEM <= 1'b0;
          RegWr_MEM    <= 1'b0;
          halt_MEM     <= 1'b0;
          WriteSrc_MEM <= '0;
        end else begin
          pc_MEM       <= pc_EX;
          instr_MEM    <= instr_EX;
          alu_out_MEM  <= alu_out_EX;
          store_q      <= store_EX;
          wsel_MEM     <= wsel_EX;
          memrd_q      <= MemRead_EX;
          memwr_q      <= MemWr_EX;
          atomic_q     <= datomic_EX;
          MemtoReg_MEM <= MemtoReg_EX;
          RegWr_MEM    <= RegWr_EX;
          halt_MEM     <= is_halt_EX;
          WriteSrc_MEM <= WriteSrc_EX;
        end
      end
      // A halted core must not keep retiring a register write.
      if (state == HALTED) RegWr_MEM <= 1'b0;
      if (access_done)              dload_MEM <= is_load ? dload : '0;
      else if (advance && !is_load) dload_MEM <= '0;
    end
  end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL be parameterless; word_t (32 bits) and the register/WriteSrc widths below SHALL be taken from cpu_types_pkg.
REQ-002 SHALL have one clock; reset is synchronous and active-high.
REQ-003 CLK  in  1  clock; all state changes on rising edge.
REQ-004 RST  in  1  synchronous active-high reset.
REQ-005 EX-side inputs:
- pc_EX, instr_EX, alu_out_EX, store_EX  in  32 each.
- wsel_EX  in  5.
- MemWr_EX, MemRead_EX, MemtoReg_EX, RegWr_EX, is_halt_EX, datomic_EX  in  1 each.
- WriteSrc_EX  in  2.
REQ-006 stall_EX_MEM  in  1  hazard-unit hold request.
REQ-007 flush_EX_MEM  in  1  hazard-unit bubble request.
REQ-008 dhit  in  1  cache completes current access this cycle.
REQ-009 dload  in  32  load data, valid when dhit.
REQ-010 Memory-request outputs:
- dREN, dWEN, datomic  out  1 each.
- daddr, dstore  out  32 each.
REQ-011 Stage outputs:
- pc_MEM, instr_MEM, alu_out_MEM, dload_MEM  out  32 each.
- wsel_MEM  out  5.
- RegWr_MEM, MemtoReg_MEM, halt_MEM, mem_busy  out  1 each.
- WriteSrc_MEM  out  2.

Function
REQ-012 State machine SHALL have exactly three states: IDLE (no pending access), ACCESS (memory op outstanding), HALTED.
REQ-013 advance SHALL equal !mem_busy && !halt_MEM && (!stall_EX_MEM || flush_EX_MEM); flush SHALL override stall but SHALL NOT override mem_busy or HALTED.
REQ-014 On advance with flush_EX_MEM=0, all _EX fields SHALL be captured into the stage register, with one-cycle latency.
REQ-015 On advance with flush_EX_MEM=1, a bubble SHALL be captured: every control bit 0, wsel 0, instr 0, data fields 0.
REQ-016 When not advancing, all registered fields SHALL hold.
REQ-017 State transitions:
- IDLE -> ACCESS when a captured entry has MemRead_EX or MemWr_EX set.
- IDLE -> HALTED when a captured entry has is_halt_EX set.
- Otherwise the state stays IDLE.
REQ-018 In ACCESS:
- dREN SHALL equal the registered MemRead.
- dWEN SHALL equal the registered MemWr.
- datomic SHALL equal the registered datomic.
- daddr SHALL equal alu_out_MEM.
- dstore SHALL equal the registered store data.
REQ-019 In IDLE and HALTED, dREN, dWEN and datomic SHALL be 0.
REQ-020 mem_busy SHALL be combinational and equal (state==ACCESS) && !dhit.
REQ-021 On dhit in ACCESS:
- dload SHALL be latched into dload_MEM (loads only; stores leave dload_MEM 0).
- The stage SHALL advance in the same cycle.
- The next state is ACCESS if the new entry is a memory op, HALTED if it is a halt, else IDLE.
REQ-022 dREN and dWEN SHALL never both be 1; if both registered bits are set, MemWr wins and dREN=0.
REQ-023 A non-memory entry SHALL drive dload_MEM=0.
REQ-024 HALTED SHALL be absorbing until RST:
- halt_MEM=1.
- Register contents hold.
- No further captures.
- RegWr_MEM is forced to 0 after the first cycle in HALTED.
REQ-025 dhit arriving outside ACCESS SHALL be ignored.

Reset
REQ-026 When RST=1 at a clock edge, the following SHALL apply:
- The state SHALL become IDLE.
- All registered outputs SHALL become 0, including halt_MEM, RegWr_MEM and WriteSrc_MEM.
- dREN, dWEN, datomic and mem_busy SHALL be 0 in the following cycle.
REQ-027 RST SHALL override every other input, including reset during ACCESS with dhit pending; the outstanding access SHALL be abandoned without latching dload.

Verification
REQ-028 ALU op, RegWr_EX=1, wsel_EX=5, alu_out_EX=0x10, no stall -> next cycle RegWr_MEM=1, wsel_MEM=5, alu_out_MEM=0x10, dREN=dWEN=0.
REQ-029 Load with alu_out_EX=0x100, dhit low for 3 cycles then high with dload=0xDEADBEEF:
- dREN=1 and daddr=0x100 for 4 cycles.
- mem_busy=1 for 3 cycles.
- dload_MEM=0xDEADBEEF after the dhit edge.
- The next entry is captured on the same edge.
REQ-030 Store with store_EX=0xA5A5A5A5, datomic_EX=1, dhit on first cycle -> dWEN=1, dstore=0xA5A5A5A5, datomic=1 for one cycle, mem_busy=0 throughout.
REQ-031 Stall and flush cases:
- stall=1, flush=0 -> stage contents unchanged.
- stall=1, flush=1 -> bubble captured (RegWr_MEM=0).
- flush=1 while mem_busy=1 -> contents held until dhit.
REQ-032 Halt and reset cases:
- is_halt_EX captured -> halt_MEM=1 sticky, later EX inputs ignored.
- RST=1 -> halt_MEM=0, state IDLE.
- RST asserted mid-ACCESS -> dREN=0 next cycle.
